ps2_key_event_decoder: RTL and testbench
========================================

Name: ps2_key_event_decoder

Overview:
- Sits directly downstream of the PS/2 controller. Consumes its raw received byte stream (received_data / received_data_en).
- Turns Set-2 scan-code sequences (plain, E0-extended, F0 break, E1 pause) into single make/break key events.
- Buffers the events in a small FIFO with a valid/ready output. Also keeps a live held-key bitmap for the game controls (arrows, space, enter).

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2
FIFO_AW, 2, log2(FIFO_DEPTH); pointer width

Ports:
CLOCK_50  input  1  system clock, 50 MHz; all logic on posedge
reset  input  1  synchronous, active-high reset
received_data  input  8  byte from PS/2 controller; sampled only when received_data_en=1
received_data_en  input  1  1-cycle strobe, one per received byte
evt_valid  output  1  FIFO non-empty; head event presented
evt_ready  input  1  consumer accepts head when evt_valid&evt_ready
evt_code  output  8  scan code of head event (final byte, prefixes stripped)
evt_ext  output  1  head event had E0 prefix
evt_break  output  1  head event is a release (F0 seen)
held_keys  output  6  live key state: [0]up E0 75, [1]down E0 72, [2]left E0 6B, [3]right E0 74, [4]space 29, [5]enter 5A
overflow  output  1  sticky: an event was dropped because FIFO full

Behaviour:
- One clock (CLOCK_50). Reset is synchronous and active-high.
- Reset values:
  - FSM=IDLE; FIFO empty, so evt_valid=0.
  - evt_code=00, evt_ext=0, evt_break=0 (head outputs read 0 when empty).
  - held_keys=000000; overflow=0; E1 skip counter=0.
- Reset asserted mid-sequence: partial prefixes are discarded and queued events are lost.
- The decoder FSM advances only on cycles with received_data_en=1. All other cycles hold state.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP with counter=7.
  - AA, FA, FE, EE, 00, FF -> ignored, stay IDLE.
  - Any other byte -> push {code,ext=0,brk=0}, stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - 12 or E0 -> discard (fake-shift / duplicate prefix), return IDLE.
  - Other -> push {code,1,0}, go IDLE.
- BRK: any byte -> push {code,0,1}, go IDLE.
- EXT_BRK:
  - 12 -> discard, go IDLE.
  - Other -> push {code,1,1}, go IDLE.
- SKIP (Pause sequence): decrement the counter per byte; return to IDLE when it reaches 0 after the 7th byte. No event is generated.
- Push timing:
  - A push writes the FIFO in the same cycle as the final strobe.
  - evt_valid rises the next cycle. Latency from final-byte strobe to evt_valid = 1 cycle.
- FIFO:
  - Pop occurs on evt_valid&evt_ready. Head outputs are registered from the read pointer. The next entry appears the cycle after a pop.
  - Full and push without pop: event dropped, overflow<=1 (sticky until reset), FIFO unchanged.
  - Full and push with pop in the same cycle: both occur, no drop, count unchanged.
  - Empty and evt_ready=1: no effect.
  - Pointers wrap modulo FIFO_DEPTH. Count is FIFO_AW+1 bits.
- held_keys:
  - Updated on every decoded event, including one dropped by overflow. The bitmap reflects the keyboard regardless of consumer backpressure.
  - Make sets the bit and break clears it, in the same cycle as the push.
  - Ext flag must match: plain 75 does not affect bit0.
  - Repeated makes (typematic) keep the bit set and each is pushed as a separate event.

Test Plan:
- Reset, then bytes 1C; F0 1C with evt_ready=1 -> events {1C,0,0} then {1C,0,1}; evt_valid high exactly 1 cycle after each final strobe.
- E0 75, then E0 F0 75 -> held_keys[0] goes 1 after 75, then 0; events {75,1,0}, {75,1,1}. Plain 75 leaves held_keys=0.
- evt_ready=0, send 5 makes (15,1D,24,2D,2C) with FIFO_DEPTH=4 -> first 4 queued, overflow=1. Drain -> 15,1D,24,2D in order, then evt_valid=0.
- FIFO full, push and pop in the same cycle -> no drop, overflow stays 0, order preserved.
- E1 14 77 E1 F0 14 F0 77, then 29 -> no events for the pause sequence, then {29,0,0} and held_keys[4]=1. Bytes AA, FA in IDLE produce nothing.
- Send E0, pulse reset, then send 6B -> event {6B,0,0} (prefix cleared), held_keys=0, FIFO empty after reset.

Source files
------------

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder
//   Turns the raw PS/2 Set-2 byte stream into single make/break key events.
//   Handles plain, E0-extended, F0 break and E1 pause sequences. Decoded
//   events are queued in a small FIFO with a valid/ready output. A live
//   held-key bitmap for the game controls is also kept, and it follows the
//   keyboard even when the consumer stalls.
//
// Ports
//   CLOCK_50          system clock, all logic on posedge
//   reset             synchronous, active-high reset
//   received_data     byte from the PS/2 controller
//   received_data_en  one-cycle strobe per received byte
//   evt_valid         FIFO non-empty, head event presented
//   evt_ready         consumer accepts the head when evt_valid & evt_ready
//   evt_code          scan code of the head event, prefixes stripped
//   evt_ext           head event had an E0 prefix
//   evt_break         head event is a release
//   held_keys         [0]up [1]down [2]left [3]right [4]space [5]enter
//   overflow          sticky, an event was dropped because the FIFO was full
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [5:0] held_keys,
    output logic       overflow
);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } event_t;

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(FIFO_DEPTH);

    state_t               state;
    logic [2:0]           skip_cnt;
    event_t               mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count;
    logic                 push;
    event_t               push_evt;
    logic                 pop;
    logic                 full;
    logic                 wr_en;
    event_t               head;

    // Decide, in the strobe cycle itself, whether this byte completes an event.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch; combinational logic uses '='.
        push     = 1'b0;
        push_evt = '{code: received_data, ext: 1'b0, brk: 1'b0};
        if (received_data_en) begin
            case (state)
                IDLE: begin
                    // Prefixes change state; ACKs, BAT results and errors are noise.
                    if (!(received_data inside {8'hE0, 8'hF0, 8'hE1, 8'hAA,
                                                8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}))
                        push = 1'b1;
                end
                EXT: begin
                    // E0 12 is the fake-shift the keyboard emits around some keys.
                    if (!(received_data inside {8'hF0, 8'h12, 8'hE0})) begin
                        push         = 1'b1;
                        push_evt.ext = 1'b1;
                    end
                end
                BRK: begin
                    push         = 1'b1;
                    push_evt.brk = 1'b1;
                end
                EXT_BRK: begin
                    if (received_data != 8'h12) begin
                        push         = 1'b1;
                        push_evt.ext = 1'b1;
                        push_evt.brk = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Prefix tracking FSM; advances only on strobe cycles.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state is always assigned with '<=' so every register
        // samples the pre-edge values of the others.
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= '0;
        end else if (received_data_en) begin
            case (state)
                IDLE: begin
                    if (received_data == 8'hE0)      state <= EXT;
                    else if (received_data == 8'hF0) state <= BRK;
                    else if (received_data == 8'hE1) begin
                        // Pause sends E1 followed by seven more bytes to swallow.
                        state    <= SKIP;
                        skip_cnt <= 3'd7;
                    end
                end
                EXT:     state <= (received_data == 8'hF0) ? EXT_BRK : IDLE;
                BRK:     state <= IDLE;
                EXT_BRK: state <= IDLE;
                SKIP: begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full  = (count == DEPTH);
    assign pop   = evt_valid & evt_ready;
    // A push into a full FIFO still goes through when the head leaves this cycle.
    assign wr_en = push & (~full | pop);

    // NOTE: the storage array has no reset; count alone defines which entries
    // are live, and the head outputs are forced to zero while empty.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem[wr_ptr] <= push_evt;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, pop};
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    // One-hot bit of held_keys addressed by an event; the E0 flag must match.
    function automatic logic [5:0] key_mask(input event_t e);
        logic [5:0] m;
        m = '0;
        case ({e.ext, e.code})
            {1'b1, 8'h75}: m[0] = 1'b1;
            {1'b1, 8'h72}: m[1] = 1'b1;
            {1'b1, 8'h6B}: m[2] = 1'b1;
            {1'b1, 8'h74}: m[3] = 1'b1;
            {1'b0, 8'h29}: m[4] = 1'b1;
            {1'b0, 8'h5A}: m[5] = 1'b1;
            default:       m    = '0;
        endcase
        return m;
    endfunction

    // Tracks every decoded event, including one the FIFO had to drop.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            held_keys <= '0;
        else if (push)
            held_keys <= push_evt.brk ? (held_keys & ~key_mask(push_evt))
                                      : (held_keys |  key_mask(push_evt));
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (count != '0);
    assign evt_code  = evt_valid ? head.code : 8'h00;
    assign evt_ext   = evt_valid & head.ext;
    assign evt_break = evt_valid & head.brk;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb_ps2_key_event_decoder
//   Self-checking bench for ps2_key_event_decoder. A reference model keeps the
//   pending prefix bytes in a queue and the event FIFO as a queue of events;
//   after every clock the DUT outputs are compared to it.
module tb_ps2_key_event_decoder;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } kev_t;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [5:0] held_keys;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    ps2_key_event_decoder #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .evt_code         (evt_code),
        .evt_ext          (evt_ext),
        .evt_break        (evt_break),
        .held_keys        (held_keys),
        .overflow         (overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model state
    kev_t       m_q[$];
    logic [7:0] m_pre[$];
    int         m_skip;
    logic [5:0] m_held;
    logic       m_ovf;

    localparam logic [7:0] KEY_CODE [6] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h5A};
    localparam logic [5:0] KEY_EXT = 6'b001111;

    function automatic logic [17:0] dut_vec();
        return {evt_valid, evt_code, evt_ext, evt_break, held_keys, overflow};
    endfunction

    function automatic logic [17:0] model_vec();
        kev_t h;
        h = (m_q.size() != 0) ? m_q[0] : '0;
        return {(m_q.size() != 0), h.code, h.ext, h.brk, m_held, m_ovf};
    endfunction

    // Effect of one clock edge with the given inputs on the model.
    task automatic model_edge(input logic [7:0] b, input logic en, input logic rdy);
        logic has;
        logic ext;
        logic brk;
        kev_t ev;
        int   sz;
        logic pop;
        has = 1'b0;
        ev  = '0;
        if (en) begin
            if (m_skip > 0) begin
                m_skip--;
            end else if (m_pre.size() == 0) begin
                if (b == 8'hE1) m_skip = 7;
                else if (b == 8'hE0 || b == 8'hF0) m_pre.push_back(b);
                else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
                    has = 1'b1;
                    ev  = '{code: b, ext: 1'b0, brk: 1'b0};
                end
            end else begin
                ext = (m_pre[0] == 8'hE0);
                brk = (m_pre[m_pre.size()-1] == 8'hF0);
                if (ext && !brk && b == 8'hF0) begin
                    m_pre.push_back(b);
                end else begin
                    if (!(ext && (b == 8'h12 || (!brk && b == 8'hE0)))) begin
                        has = 1'b1;
                        ev  = '{code: b, ext: ext, brk: brk};
                    end
                    m_pre.delete();
                end
            end
        end
        sz  = m_q.size();
        pop = (sz != 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (has) begin
            for (int i = 0; i < 6; i++)
                if (ev.code == KEY_CODE[i] && ev.ext == KEY_EXT[i]) m_held[i] = !ev.brk;
            if (sz == DEPTH && !pop) m_ovf = 1'b1;
            else m_q.push_back(ev);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next one.
    task automatic step(input logic [7:0] b, input logic en, input logic rdy);
        received_data    = b;
        received_data_en = en;
        evt_ready        = rdy;
        model_edge(b, en, rdy);
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
        evt_ready        = 1'b0;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        received_data_en = 1'b0;
        evt_ready        = 1'b0;
        received_data    = 8'h00;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        m_q.delete();
        m_pre.delete();
        m_skip = 0;
        m_held = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_break, held_keys, overflow} !== 18'h0) begin
            failures++;
            $display("FAIL reset_state: got %h required 00000", dut_vec());
        end
    endtask

    task automatic test_basic();
        logic [7:0] seq [3] = '{8'h1C, 8'hF0, 8'h1C};
        for (int i = 0; i < 3; i++) begin
            step(seq[i], 1'b1, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL basic[%0d]: got %h required %h", i, dut_vec(), model_vec());
            end
        end
        // Break event must be presented one cycle after its final byte.
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL basic_break: got %b/%h/%b/%b required 1/1c/0/1",
                     evt_valid, evt_code, evt_ext, evt_break);
        end
        step(8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_arrows();
        logic [7:0] seq [6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h75};
        for (int i = 0; i < 6; i++) begin
            step(seq[i], 1'b1, 1'b1);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL arrows[%0d]: got %h required %h", i, dut_vec(), model_vec());
            end
            if (i == 1) begin
                checks++;
                if (held_keys !== 6'b000001 || evt_code !== 8'h75 || evt_ext !== 1'b1) begin
                    failures++;
                    $display("FAIL arrow_up_make: held %b code %h ext %b required 000001 75 1",
                             held_keys, evt_code, evt_ext);
                end
            end
        end
        // Plain 75 (keypad 8) must not touch the up-arrow bit.
        checks++;
        if (held_keys !== 6'b000000) begin
            failures++;
            $display("FAIL plain_75: held %b required 000000", held_keys);
        end
        step(8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        logic [7:0] keys [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        do_reset();
        foreach (keys[i]) step(keys[i], 1'b1, 1'b0);
        checks++;
        if (overflow !== 1'b1 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL overflow_set: ovf %b vec %h required 1 / %h",
                     overflow, dut_vec(), model_vec());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_code !== keys[i]) begin
                failures++;
                $display("FAIL overflow_drain[%0d]: valid %b code %h required 1 %h",
                         i, evt_valid, evt_code, keys[i]);
            end
            step(8'h00, 1'b0, 1'b1);
        end
        checks++;
        if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_empty: valid %b ovf %b required 0 1", evt_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] keys [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        do_reset();
        for (int i = 0; i < 4; i++) step(keys[i], 1'b1, 1'b0);
        step(keys[4], 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b0 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL full_push_pop: ovf %b vec %h required 0 / %h",
                     overflow, dut_vec(), model_vec());
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_code !== keys[i]) begin
                failures++;
                $display("FAIL full_drain[%0d]: valid %b code %h required 1 %h",
                         i, evt_valid, evt_code, keys[i]);
            end
            step(8'h00, 1'b0, 1'b1);
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_empty: valid %b required 0", evt_valid);
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [10] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14,
                                 8'hF0, 8'h77, 8'hAA, 8'hFA};
        do_reset();
        foreach (seq[i]) begin
            step(seq[i], 1'b1, 1'b0);
            checks++;
            if (evt_valid !== 1'b0 || dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL pause[%0d]: got %h required %h", i, dut_vec(), model_vec());
            end
        end
        step(8'h29, 1'b1, 1'b0);
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_break, held_keys} !==
            {1'b1, 8'h29, 1'b0, 1'b0, 6'b010000}) begin
            failures++;
            $display("FAIL pause_then_space: got %h required 29 event, held 010000", dut_vec());
        end
    endtask

    task automatic test_reset_mid();
        step(8'hE0, 1'b1, 1'b0);
        do_reset();
        checks++;
        if (evt_valid !== 1'b0 || held_keys !== 6'b0) begin
            failures++;
            $display("FAIL reset_mid_empty: valid %b held %b required 0 000000",
                     evt_valid, held_keys);
        end
        step(8'h6B, 1'b1, 1'b0);
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_break, held_keys} !==
            {1'b1, 8'h6B, 1'b0, 1'b0, 6'b0}) begin
            failures++;
            $display("FAIL reset_mid_6b: got %h required plain 6b event, held 0", dut_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] game [6] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h5A};
        logic [7:0] noise [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        logic [7:0] b;
        int r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 39);
            if (r < 6)       b = 8'hE0;
            else if (r < 11) b = 8'hF0;
            else if (r == 11) b = 8'hE1;
            else if (r == 12) b = 8'h12;
            else if (r < 25) b = game[$urandom_range(0, 5)];
            else if (r < 28) b = noise[$urandom_range(0, 5)];
            else             b = 8'($urandom);
            step(b, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 5));
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL random[%0d] byte %h: got %h required %h",
                         i, b, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        received_data    = 8'h00;
        received_data_en = 1'b0;
        evt_ready        = 1'b0;
        m_skip           = 0;
        m_held           = '0;
        m_ovf            = 1'b0;
        test_reset();
        test_basic();
        test_arrows();
        test_overflow();
        test_full_push_pop();
        test_pause();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
